// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
//   DEF_WIDTH / DEF_DEPTH : default geometry (matches the legacy 8x9 FIFO)
//   ptr_wrap()            : pointer increment that keeps the extra wrap bit
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_DEPTH = 8;

    // Increment an (aw+1)-bit pointer held in the low bits of a 32-bit word.
    // The top (wrap) bit toggles each time the address field rolls over.
    function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr, input int aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, registered read.
//   clk           : clock, rising edge
//   rst           : sync active-high, clears only the read register
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates on the next edge, else holds
//   rdata         : registered read data
module fifo_ram_1r1w #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is intentionally not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level count, sticky overflow/underflow
// and programmable almost-full / almost-empty watermarks.
//   clk, rst       : clock, sync active-high reset
//   clr            : sync flush (pointers/count/flags), storage and dout kept
//   wr_en, din     : push request and data
//   rd_en          : pop request
//   dout           : registered pop data (1-cycle latency)
//   dout_valid     : dout was popped by the previous edge
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : sticky error flags
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int AFULL_TH  = DEPTH - 2,
    parameter  int AEMPTY_TH = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = AW + 1;
    localparam logic [AW:0] AF_TH = PW'(AFULL_TH);
    // A threshold at or above DEPTH simply means "always almost empty".
    localparam logic [AW:0] AE_TH = PW'((AEMPTY_TH > DEPTH) ? DEPTH : AEMPTY_TH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0))
            $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
        if (AFULL_TH > DEPTH)
            $fatal(1, "sync_fifo_param: AFULL_TH must not exceed DEPTH");
    endgenerate

    logic [AW:0] wr_ptr, rd_ptr;
    logic        push_ok, pop_ok;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    // rst and clr both swallow any handshake in the same cycle.
    assign push_ok = wr_en && !full  && !clr && !rst;
    assign pop_ok  = rd_en && !empty && !clr && !rst;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= PW'(ptr_wrap(32'(wr_ptr), AW));
            if (pop_ok)  rd_ptr <= PW'(ptr_wrap(32'(rd_ptr), AW));
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            dout_valid <= pop_ok;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    fifo_ram_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (din),
        .re    (pop_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, rd_en;
    logic [8:0] din, dout;
    logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    // 16x16 instance for the parameter sweep
    logic        b_clr, b_wr_en, b_rd_en;
    logic [15:0] b_din, b_dout;
    logic        b_dout_valid, b_full, b_empty, b_almost_full, b_almost_empty;
    logic        b_overflow, b_underflow;
    logic [4:0]  b_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.WIDTH(16), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(3)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .wr_en(b_wr_en), .din(b_din), .rd_en(b_rd_en),
        .dout(b_dout), .dout_valid(b_dout_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_almost_full), .almost_empty(b_almost_empty), .count(b_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic flush();
        clr = 1; wr_en = 0; rd_en = 0;
        tick();
        clr = 0;
    endtask

    task automatic push(input logic [8:0] v);
        wr_en = 1; rd_en = 0; din = v;
        tick();
        wr_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); din = '0;
        b_clr = 0; b_wr_en = 0; b_rd_en = 0; b_din = '0;
        tick(); tick();
        rst = 0;
        tests++;
        if ({count, empty, almost_empty, full, almost_full} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        tests++;
        if ({dout, dout_valid, overflow, underflow} !== {9'h000, 3'b000}) begin
            fails++;
            $display("FAIL reset_out: got dout=%h dv=%b ov=%b un=%b, want 000 0 0 0",
                     dout, dout_valid, overflow, underflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            push(9'(i));
            tests++;
            if ({count, full, almost_full, empty} !== {4'(i), i == 8, i >= 6, 1'b0}) begin
                fails++;
                $display("FAIL fill_%0d: got cnt=%0d f=%b af=%b e=%b, want %0d %b %b 0",
                         i, count, full, almost_full, empty, i, i == 8, i >= 6);
            end
        end
        push(9'h1FF);
        tests++;
        if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1}) begin
            fails++;
            $display("FAIL fill_overflow: got ov=%b cnt=%0d f=%b, want 1 8 1", overflow, count, full);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1;
            tick();
            tests++;
            if ({dout, dout_valid, count, empty} !== {9'(i), 1'b1, 4'(8 - i), i == 8}) begin
                fails++;
                $display("FAIL drain_%0d: got dout=%h dv=%b cnt=%0d e=%b, want %h 1 %0d %b",
                         i, dout, dout_valid, count, empty, 9'(i), 8 - i, i == 8);
            end
        end
        tick();  // 9th pop on empty
        rd_en = 0;
        tests++;
        if ({underflow, dout, dout_valid, count} !== {1'b1, 9'h008, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL drain_underflow: got un=%b dout=%h dv=%b cnt=%0d, want 1 008 0 0",
                     underflow, dout, dout_valid, count);
        end
        tick();
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_dv_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_wrap();
        flush();
        for (int i = 0; i < 5; i++) push(9'h010 + 9'(i));
        for (int i = 0; i < 5; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            tests++;
            if (dout !== 9'h010 + 9'(i)) begin
                fails++;
                $display("FAIL wrap_a_%0d: got %h want %h", i, dout, 9'h010 + 9'(i));
            end
        end
        for (int i = 0; i < 6; i++) push(9'h020 + 9'(i));
        tests++;
        if (count !== 4'd6) begin
            fails++;
            $display("FAIL wrap_peak: got cnt=%0d want 6", count);
        end
        for (int i = 0; i < 6; i++) begin
            rd_en = 1; tick(); rd_en = 0;
            tests++;
            if (dout !== 9'h020 + 9'(i)) begin
                fails++;
                $display("FAIL wrap_b_%0d: got %h want %h", i, dout, 9'h020 + 9'(i));
            end
        end
        tests++;
        if ({count, empty} !== {4'd0, 1'b1}) begin
            fails++;
            $display("FAIL wrap_end: got cnt=%0d e=%b want 0 1", count, empty);
        end
    endtask

    task automatic test_simul();
        logic [8:0] exp;
        flush();
        for (int i = 0; i < 4; i++) push(9'h030 + 9'(i));
        for (int k = 0; k < 10; k++) begin
            wr_en = 1; rd_en = 1; din = 9'h040 + 9'(k);
            tick();
            exp = (k < 4) ? 9'h030 + 9'(k) : 9'h040 + 9'(k - 4);
            tests++;
            if ({dout, dout_valid, count} !== {exp, 1'b1, 4'd4}) begin
                fails++;
                $display("FAIL simul_%0d: got dout=%h dv=%b cnt=%0d, want %h 1 4",
                         k, dout, dout_valid, count, exp);
            end
        end
        idle();
        // push+pop while full
        flush();
        for (int i = 0; i < 8; i++) push(9'h050 + 9'(i));
        wr_en = 1; rd_en = 1; din = 9'h0EE;
        tick(); idle();
        tests++;
        if ({count, overflow, dout, dout_valid} !== {4'd7, 1'b1, 9'h050, 1'b1}) begin
            fails++;
            $display("FAIL simul_full: got cnt=%0d ov=%b dout=%h dv=%b, want 7 1 050 1",
                     count, overflow, dout, dout_valid);
        end
        // push+pop while empty
        flush();
        wr_en = 1; rd_en = 1; din = 9'h077;
        tick(); idle();
        tests++;
        if ({count, underflow, dout_valid} !== {4'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL simul_empty: got cnt=%0d un=%b dv=%b, want 1 1 0", count, underflow, dout_valid);
        end
        rd_en = 1; tick(); rd_en = 0;
        tests++;
        if ({dout, dout_valid} !== {9'h077, 1'b1}) begin
            fails++;
            $display("FAIL simul_empty_rd: got dout=%h dv=%b, want 077 1", dout, dout_valid);
        end
    endtask

    task automatic test_flush();
        flush();
        for (int i = 0; i < 8; i++) push(9'h060 + 9'(i));
        push(9'h1FF);  // sets overflow
        for (int i = 0; i < 3; i++) begin
            rd_en = 1; tick(); rd_en = 0;
        end
        tests++;
        if ({count, overflow} !== {4'd5, 1'b1}) begin
            fails++;
            $display("FAIL flush_pre: got cnt=%0d ov=%b want 5 1", count, overflow);
        end
        clr = 1; wr_en = 1; din = 9'h155;
        tick();
        clr = 0; wr_en = 0;
        tests++;
        if ({count, empty, overflow, dout_valid, dout} !== {4'd0, 1'b1, 1'b0, 1'b0, 9'h062}) begin
            fails++;
            $display("FAIL flush_clr: got cnt=%0d e=%b ov=%b dv=%b dout=%h, want 0 1 0 0 062",
                     count, empty, overflow, dout_valid, dout);
        end
        push(9'h0AA);
        rd_en = 1; tick(); rd_en = 0;
        tests++;
        if ({dout, dout_valid, count} !== {9'h0AA, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL flush_after: got dout=%h dv=%b cnt=%0d, want 0aa 1 0", dout, dout_valid, count);
        end
    endtask

    task automatic test_sweep();
        tests++;
        if ({b_almost_empty, b_almost_full, b_empty} !== 3'b101) begin
            fails++;
            $display("FAIL sweep_init: got ae=%b af=%b e=%b want 1 0 1", b_almost_empty, b_almost_full, b_empty);
        end
        for (int k = 1; k <= 16; k++) begin
            b_wr_en = 1; b_din = 16'hA000 + 16'(k);
            tick();
            b_wr_en = 0;
            tests++;
            if ({b_count, b_almost_full, b_almost_empty, b_full} !== {5'(k), k >= 12, k <= 3, k == 16}) begin
                fails++;
                $display("FAIL sweep_%0d: got cnt=%0d af=%b ae=%b f=%b, want %0d %b %b %b",
                         k, b_count, b_almost_full, b_almost_empty, b_full, k, k >= 12, k <= 3, k == 16);
            end
        end
        b_rd_en = 1; tick(); b_rd_en = 0;
        tests++;
        if ({b_dout, b_count} !== {16'hA001, 5'd15}) begin
            fails++;
            $display("FAIL sweep_rd: got dout=%h cnt=%0d, want a001 15", b_dout, b_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_flush();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
